issue_select: RTL

- Pop-side consumer of an issue_buffer: scans the buffer's valid entries, checks both source operands against the physical-register ready bitmap, and picks one ready entry per cycle.
- Drives the buffer's issue_pop / issue_pop_index, and registers the popped micro-op into a one-deep valid/ready output stage that feeds the execution unit (adder, jal, logCmp, lu).
- One instance per issue_buffer, in stage C4 between T3 (issue buffers) and T4 (exe params).

---
 rtl/issue_select.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/issue_select.sv
// issue_select: pop-side picker for one issue_buffer.
// Scans the valid slots and checks both source operands against the
// physical-register ready bitmap (wakeup and select happen in the same
// cycle). It picks one ready slot per cycle, pops it from the buffer and
// registers the micro-op into a one-deep valid/ready stage feeding the
// execution unit.
// Build option: define ISSUE_SELECT_AGE_ORDER_EN for oldest-first selection
// through an age matrix. Without it, selection is the lowest-index ready
// slot and the push inputs are ignored.

// Per-slot wakeup check: the slot is a candidate when it is valid and both
// of its source registers have been written back.
module issue_select_slot #(
    parameter int RNAME_DW = 6,
    parameter int PHY_DP   = 64
) (
    input  logic                vld,
    input  logic [RNAME_DW-1:0] rs1,
    input  logic [RNAME_DW-1:0] rs2,
    input  logic [PHY_DP-1:0]   reg_ready,
    output logic                cand
);

    assign cand = vld & reg_ready[rs1] & reg_ready[rs2];

endmodule

module issue_select #(
    parameter int DW       = 64,
    parameter int DP       = 8,
    parameter int RNAME_DW = 6,
    parameter int PHY_DP   = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   issue_push,
    input  logic [$clog2(DP)-1:0]  issue_push_index,
    input  logic [DP-1:0]          buffer_vaild_qout,
    input  logic [DP*DW-1:0]       issue_info_qout,
    input  logic [DP*RNAME_DW-1:0] rs1_qout,
    input  logic [DP*RNAME_DW-1:0] rs2_qout,
    input  logic [PHY_DP-1:0]      regReady,
    output logic                   issue_pop,
    output logic [$clog2(DP)-1:0]  issue_pop_index,
    output logic [DW-1:0]          exe_info,
    output logic                   exe_valid,
    input  logic                   exe_ready
);

    localparam int IW = $clog2(DP);

    logic [DP-1:0] cand;       // valid and both operands ready
    logic [DP-1:0] sel_vec;    // candidates with no older candidate
    logic [DP-1:0] sel_pool;   // set the final encoder picks from
    logic [IW-1:0] sel_idx;
    logic          any_cand;
    logic          stage_free;

    logic          exe_valid_q, exe_valid_d;
    logic [DW-1:0] exe_info_q,  exe_info_d;

    // One wakeup checker per buffer slot
    for (genvar g = 0; g < DP; g++) begin : g_slot
        issue_select_slot #(
            .RNAME_DW (RNAME_DW),
            .PHY_DP   (PHY_DP)
        ) u_slot (
            .vld       (buffer_vaild_qout[g]),
            .rs1       (rs1_qout[g*RNAME_DW +: RNAME_DW]),
            .rs2       (rs2_qout[g*RNAME_DW +: RNAME_DW]),
            .reg_ready (regReady),
            .cand      (cand[g])
        );
    end

`ifdef ISSUE_SELECT_AGE_ORDER_EN
    // older_q[i][j] = 1: slot j entered the buffer before slot i
    logic [DP-1:0][DP-1:0] older_q, older_d;

    // A candidate is eligible when none of the slots older than it is also a candidate
    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < DP; i++) begin
            sel_vec[i] = cand[i] & ~(|(older_q[i] & cand));
        end
    end

    // Age update: a push makes its slot youngest, a pop retires its column, flush wipes all
    always_comb begin
        older_d = older_q;
        if (flush) begin
            older_d = '0;
        end else begin
            if (issue_push) begin
                for (int r = 0; r < DP; r++) begin
                    older_d[r][issue_push_index] = 1'b0;
                end
                older_d[issue_push_index] = buffer_vaild_qout & ~(DP'(1) << issue_push_index);
            end
            if (issue_pop) begin
                for (int r = 0; r < DP; r++) begin
                    older_d[r][issue_pop_index] = 1'b0;
                end
            end
        end
    end

    // Age matrix register
    always_ff @(posedge CLK) begin
        if (RST) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    // Pushing and popping the same slot in one cycle means the buffer owner is broken
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(issue_push && issue_pop && (issue_push_index == issue_pop_index)));
        end
    end
`else
    // Fixed priority: every candidate is eligible, and the encoder takes the lowest index
    logic unused_push;
    assign unused_push = ^{issue_push, issue_push_index};

    always_comb begin
        sel_vec = cand;
    end
`endif

    // Slots that were valid before any push was tracked (after reset or flush) share an
    // all-zero age row. They can tie, so the lowest index wins. The raw candidate set
    // is a fallback that keeps the pick on a real candidate even if the age state is inconsistent.
    always_comb begin
        sel_pool = (|sel_vec) ? sel_vec : cand;
        sel_idx  = '0;
        for (int i = DP - 1; i >= 0; i--) begin
            if (sel_pool[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    assign any_cand        = |cand;
    assign stage_free      = ~exe_valid_q | exe_ready;
    assign issue_pop       = any_cand & stage_free & ~flush & ~RST;
    assign issue_pop_index = issue_pop ? sel_idx : '0;

    // Output stage: load on pop, drain on accept, otherwise hold stable for the consumer
    always_comb begin
        exe_valid_d = exe_valid_q;
        exe_info_d  = exe_info_q;
        if (flush) begin
            exe_valid_d = 1'b0;
        end else if (issue_pop) begin
            exe_valid_d = 1'b1;
            exe_info_d  = issue_info_qout[sel_idx*DW +: DW];
        end else if (exe_ready) begin
            exe_valid_d = 1'b0;
        end
    end

    // Output stage register
    always_ff @(posedge CLK) begin
        if (RST) begin
            exe_valid_q <= 1'b0;
            exe_info_q  <= '0;
        end else begin
            exe_valid_q <= exe_valid_d;
            exe_info_q  <= exe_info_d;
        end
    end

    assign exe_valid = exe_valid_q;
    assign exe_info  = exe_info_q;

endmodule
